// File: rtl/reg_decoder_n.sv
// Registered N-to-2**N decoder with valid/ready handshakes. Supports one-hot, thermometer,
// active-low one-hot and a multi-word scan mode that walks a one-hot bit up to a target.
module reg_decoder_n #(
  parameter int unsigned N       = 3,
  parameter bit          INV_RST = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    In,
  input  logic [1:0]      mode,
  input  logic            en,
  output logic [2**N-1:0] O,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy
);

  localparam int unsigned W = 2 ** N;
  localparam logic [W-1:0] ORst = {W{INV_RST}};
  localparam logic [N-1:0] CntOne = N'(1);

  typedef enum logic [1:0] {StIdle, StHold, StScan} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   o_q, o_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic [N-1:0]   target_q, target_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;

  logic           accept;
  logic           out_hs;
  logic           do_load;
  logic [W-1:0]   req_word;

  function automatic logic [W-1:0] onehot(input logic [N-1:0] idx);
    logic [W-1:0] r;
    for (int unsigned i = 0; i < W; i++) begin
      r[i] = (N'(i) == idx);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] thermo(input logic [N-1:0] idx);
    logic [W-1:0] r;
    for (int unsigned i = 0; i < W; i++) begin
      r[i] = (N'(i) <= idx);
    end
    return r;
  endfunction

  // Reset forces in_ready low even before the state flop settles.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StIdle:  in_ready = 1'b1;
        StHold:  in_ready = out_ready;
        StScan:  in_ready = 1'b0;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready;
  assign out_hs = valid_q && out_ready;

  // Single-word result for every non-scan request; a disabled request blanks the word.
  always_comb begin
    req_word = '0;
    if (!en) begin
      req_word = (mode == 2'b11) ? '1 : '0;
    end else begin
      unique case (mode)
        2'b00:   req_word = onehot(In);
        2'b01:   req_word = thermo(In);
        2'b11:   req_word = ~onehot(In);
        default: req_word = '0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    o_d      = o_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    do_load  = 1'b0;

    unique case (state_q)
      StIdle: begin
        do_load = accept;
      end
      StHold: begin
        if (accept) begin
          do_load = 1'b1;
        end else if (out_hs) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      StScan: begin
        if (out_hs) begin
          if (cnt_q == target_q) begin
            state_d = StIdle;
            valid_d = 1'b0;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CntOne;
            o_d   = onehot(cnt_q + CntOne);
          end
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    if (do_load) begin
      valid_d = 1'b1;
      if (mode == 2'b10 && en) begin
        state_d  = StScan;
        target_d = In;
        cnt_d    = '0;
        o_d      = onehot('0);
        busy_d   = 1'b1;
      end else begin
        state_d = StHold;
        o_d     = req_word;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      o_q      <= ORst;
      cnt_q    <= '0;
      target_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      o_q      <= o_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign O         = o_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_reg_decoder_n.sv
// Self-checking bench for reg_decoder_n: directed cases plus random traffic against a
// word-queue model of the output stream.
module tb_reg_decoder_n;

  localparam int unsigned N = 3;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_sel;
  logic [1:0]   mode;
  logic         en;
  logic [W-1:0] o_word;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model: pending output words in order, whether a scan owns them, and the last word taken.
  logic [W-1:0] exp_q[$];
  bit           m_scan;
  logic [W-1:0] m_last;

  reg_decoder_n #(
    .N      (N),
    .INV_RST(1'b0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .In       (in_sel),
    .mode     (mode),
    .en       (en),
    .O        (o_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_word(input int sel, input int md, input bit e);
    int v;
    if (!e) return (md == 3) ? 8'hFF : 8'h00;
    case (md)
      0:       v = 1 << sel;
      1:       v = (2 << sel) - 1;
      3:       v = ~(1 << sel);
      default: v = 0;
    endcase
    return v[W-1:0];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_scan = 1'b0;
    m_last = 8'h00;
  endtask

  task automatic check_outputs(input logic ordy);
    bit exp_ready;
    if (exp_q.size() == 0) exp_ready = 1'b1;
    else if (m_scan)       exp_ready = 1'b0;
    else                   exp_ready = ordy;
    check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check_eq("busy", 32'(busy), 32'(m_scan));
    check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
    check_eq("O", 32'(o_word), 32'((exp_q.size() != 0) ? exp_q[0] : m_last));
  endtask

  // One clock: drive on the falling edge, check, advance the model, then let the rising edge hit.
  task automatic cycle(input bit iv, input int sel, input int md, input bit e, input bit ordy);
    bit exp_ready;
    bit acc;
    bit hs;
    @(negedge clk);
    in_valid  = iv;
    in_sel    = sel[N-1:0];
    mode      = md[1:0];
    en        = e;
    out_ready = ordy;
    #1;
    check_outputs(ordy);
    if (exp_q.size() == 0) exp_ready = 1'b1;
    else if (m_scan)       exp_ready = 1'b0;
    else                   exp_ready = ordy;
    acc = iv && exp_ready;
    hs  = (exp_q.size() != 0) && ordy;
    if (hs) begin
      m_last = exp_q.pop_front();
      if (exp_q.size() == 0) m_scan = 1'b0;
    end
    if (acc) begin
      if (md == 2 && e) begin
        for (int k = 0; k <= sel; k++) exp_q.push_back(8'(1 << k));
        m_scan = 1'b1;
      end else begin
        exp_q.push_back(model_word(sel, md, e));
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    mode      = 2'b00;
    en        = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_O", 32'(o_word), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // One-hot In=5, then return to idle.
    cycle(1'b1, 5, 0, 1'b1, 1'b1);
    cycle(1'b0, 0, 0, 1'b1, 1'b1);
    check_eq("onehot5", 32'(o_word), 32'h20);
    idle_cycles(1);
    // Thermometer, active-low one-hot, disabled request, disabled inverted request.
    cycle(1'b1, 3, 1, 1'b1, 1'b1);
    cycle(1'b1, 3, 3, 1'b1, 1'b1);
    cycle(1'b1, 6, 0, 1'b0, 1'b1);
    cycle(1'b1, 6, 3, 1'b0, 1'b1);
    cycle(1'b1, 7, 1, 1'b1, 1'b1);
    cycle(1'b1, 0, 1, 1'b1, 1'b1);
    idle_cycles(2);
    // Scan to 3 with continuous consumption, then disabled scan request.
    cycle(1'b1, 3, 2, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1, 0, 1'b1, 1'b1);
    cycle(1'b1, 4, 2, 1'b0, 1'b1);
    idle_cycles(2);
    // Back-to-back one-hot requests with no bubble.
    cycle(1'b1, 0, 0, 1'b1, 1'b1);
    cycle(1'b1, 1, 0, 1'b1, 1'b1);
    cycle(1'b1, 7, 0, 1'b1, 1'b1);
    idle_cycles(2);
    // Full scan with ready toggling 1,0,0,1.
    cycle(1'b1, 7, 2, 1'b1, 1'b1);
    for (int i = 0; i < 40 && (exp_q.size() != 0); i++) begin
      cycle(1'b1, 2, 0, 1'b1, (i % 4 == 0) || (i % 4 == 3));
    end
    check_eq("scan7_drained", 32'(exp_q.size()), 32'd0);
    idle_cycles(2);
    // Scan of a single word, held off under back-pressure first.
    cycle(1'b1, 0, 2, 1'b1, 1'b0);
    cycle(1'b1, 5, 0, 1'b1, 1'b0);
    cycle(1'b1, 5, 0, 1'b1, 1'b1);
    idle_cycles(2);

    // Reset mid-scan once 0x04 is on the output.
    cycle(1'b1, 7, 2, 1'b1, 1'b1);
    cycle(1'b0, 0, 0, 1'b1, 1'b1);
    cycle(1'b0, 0, 0, 1'b1, 1'b1);
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    check_eq("pre_rst_O", 32'(o_word), 32'h04);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_O", 32'(o_word), 32'h00);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1, 0, 1'b1, 1'b1);
    cycle(1'b0, 0, 0, 1'b1, 1'b1);
    check_eq("post_rst_O", 32'(o_word), 32'h02);
    idle_cycles(1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 40 && (exp_q.size() != 0); i++) cycle(1'b0, 0, 0, 1'b1, 1'b1);
    check_eq("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_decoder_n.md
REG_DECODER_N -- requirements
Module: reg_decoder_n

Interface
REQ-001 SHALL have parameter N, default 3: select width; output width is 2**N.
REQ-002 SHALL have parameter INV_RST, default 0: if 1, O resets to all-ones instead of all-zeros.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  request present on In/mode/en.
REQ-006 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port In  input  N  select code.
REQ-008 SHALL have port mode  input  2  operation: 00 one-hot, 01 thermometer, 10 scan, 11 active-low one-hot.
REQ-009 SHALL have port en  input  1  request enable; 0 yields a blank word.
REQ-010 SHALL have port O  output  2**N  registered decoded word.
REQ-011 SHALL have port out_valid  output  1  O holds a valid word.
REQ-012 SHALL have port out_ready  input  1  consumer takes O this cycle.
REQ-013 SHALL have port busy  output  1  scan sequence in progress.

Function
REQ-014 SHALL accept a request when in_valid && in_ready on a rising clk edge; In, mode, en are captured there.
REQ-015 SHALL produce an output handshake when out_valid && out_ready on a rising clk edge.
REQ-016 SHALL implement states IDLE, HOLD, SCAN; IDLE: out_valid=0; HOLD and SCAN: out_valid=1.
REQ-017 SHALL drive in_ready = 1 in IDLE, = out_ready in HOLD, = 0 in SCAN, = 0 while rst_n is low.
REQ-018 SHALL load O one cycle after acceptance (latency 1): mode 00 -> bit In set, others 0.
REQ-019 SHALL for mode 01 load O with bits 0..In set, bits above In clear (In=0 -> 0x..01, In=2**N-1 -> all ones).
REQ-020 SHALL for mode 11 load O as bitwise inverse of the mode-00 word.
REQ-021 SHALL for en=0 load O = all zeros (all ones for mode 11), go HOLD, never enter SCAN.
REQ-022 SHALL on mode 00/01/11 acceptance go to HOLD; in HOLD on output handshake go IDLE unless a new request is accepted in the same cycle, in which case load the new word and stay HOLD (full throughput, no bubble).
REQ-023 SHALL for mode 10 with en=1 capture target=In, set counter cnt=0, load O = one-hot(0), enter SCAN, assert busy.
REQ-024 SHALL in SCAN on each output handshake increment cnt and load O = one-hot(cnt+1); on the handshake with cnt == target, go IDLE, clear busy, clear out_valid (one-cycle bubble before next acceptance).
REQ-025 SHALL emit exactly target+1 words per scan; target=0 emits single word one-hot(0).
REQ-026 SHALL hold O, out_valid, cnt, state stable while out_valid=1 and out_ready=0 (back-pressure, any duration).
REQ-027 SHALL ignore In, mode, en, in_valid when in_ready=0.
REQ-028 SHALL keep cnt width N; cnt never exceeds target so no wrap occurs (target=2**N-1 reaches all-ones cnt and terminates).
REQ-029 SHALL leave O unchanged in IDLE (last word retained, out_valid=0).

Reset
REQ-030 SHALL on rst_n low, immediately and independent of clk: state=IDLE, out_valid=0, busy=0, cnt=0, target=0, O = 0 (all ones if INV_RST=1).
REQ-031 SHALL abort any HOLD or SCAN on reset mid-operation with no further words emitted; first acceptance is possible on the first rising clk edge after rst_n deasserts.

Verification
REQ-032 SHALL cover: N=3, reset, mode 00, In=5, en=1, out_ready=1 -> next cycle O=0x20, out_valid=1; then IDLE.
REQ-033 SHALL cover: mode 01 In=3 -> O=0x0F; mode 11 In=3 -> O=0xF7; en=0 mode 00 -> O=0x00.
REQ-034 SHALL cover: mode 10 In=3, out_ready=1 -> O sequence 0x01,0x02,0x04,0x08 on 4 consecutive cycles, busy high throughout, in_ready=0, then IDLE with busy=0.
REQ-035 SHALL cover: back-to-back mode 00 requests In=0,1,7 with in_valid and out_ready held high -> O=0x01,0x02,0x80 on consecutive cycles, no bubble.
REQ-036 SHALL cover: scan In=7 with out_ready toggling 1,0,0,1 -> O held stable during low cycles, all 8 words delivered in order exactly once.
REQ-037 SHALL cover: rst_n pulled low mid-scan after word 0x04 -> out_valid, busy drop asynchronously, O=0x00; post-reset request mode 00 In=1 -> O=0x02.
